// File: rtl/stopwatch_counter.sv
// Four-digit BCD up/down time counter (00.00 .. 99.99) paced by a clock prescaler.
// Saturates at either end; at_limit is a live decode of count against the current direction.
module stopwatch_counter #(
  parameter int unsigned TICK_DIV   = 1_000_000,
  parameter int unsigned PRESCALE_W = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        addsub,
  input  logic        load_preset,
  input  logic [1:0]  mode,
  input  logic [7:0]  preset_bcd,
  output logic [15:0] count,
  output logic        tick,
  output logic        at_limit
);

  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(TICK_DIV - 1);

  logic [PRESCALE_W-1:0] prescale;
  logic                  wrap;
  logic [15:0]           preset_val;
  logic [15:0]           start_val;

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // One BCD increment/decrement with ripple carry/borrow; saturation is handled by the caller.
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] r;
    logic        rip;
    r   = v;
    rip = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (rip) begin
        if (up) begin
          if (v[4*i +: 4] >= 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            rip = 1'b0;
          end
        end else begin
          if (v[4*i +: 4] == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            rip = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign wrap       = (prescale == PRESCALE_LAST);
  assign preset_val = {clamp9(preset_bcd[7:4]), clamp9(preset_bcd[3:0]), 8'h00};
  assign at_limit   = addsub ? (count == 16'h9999) : (count == 16'h0000);

  always_comb begin
    start_val = 16'h0000;
    case (mode)
      2'b00:   start_val = 16'h0000;
      2'b10:   start_val = 16'h9999;
      default: start_val = preset_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count    <= 16'h0000;
      prescale <= '0;
      tick     <= 1'b0;
    end else if (load_preset) begin
      count    <= start_val;
      prescale <= '0;
      tick     <= 1'b0;
    end else if (enable) begin
      tick <= wrap;
      if (wrap) begin
        prescale <= '0;
        if (!at_limit) count <= bcd_step(count, addsub);
      end else begin
        prescale <= prescale + 1'b1;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboarded bench for stopwatch_counter with TICK_DIV = 4: each step pushes its expected
// count, a monitor pops and compares on every tick; loads and boundaries are checked directly.
module tb_stopwatch_counter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        addsub;
  logic        load_preset;
  logic [1:0]  mode;
  logic [7:0]  preset_bcd;
  logic [15:0] count;
  logic        tick;
  logic        at_limit;

  int          errors = 0;
  int          checks = 0;
  int          model_val = 0;
  logic [15:0] exp_q[$];

  stopwatch_counter #(.TICK_DIV(4), .PRESCALE_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .addsub      (addsub),
    .load_preset (load_preset),
    .mode        (mode),
    .preset_bcd  (preset_bcd),
    .count       (count),
    .tick        (tick),
    .at_limit    (at_limit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every tick is a presented result and must match the oldest queued expectation.
  initial begin
    logic bad;
    forever begin
      @(negedge clk);
      if (tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tick", count, 16'hxxxx);
        end else begin
          check("step_count", count, exp_q.pop_front());
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) if (count[4*i +: 4] > 4'd9) bad = 1'b1;
        check("bcd_legal", {15'd0, bad}, 16'd0);
      end
    end
  end

  task automatic do_load(input logic [1:0] m, input logic [7:0] p, input logic [15:0] exp_hex,
                         input string name);
    mode        = m;
    preset_bcd  = p;
    load_preset = 1'b1;
    @(negedge clk);
    load_preset = 1'b0;
    check(name, count, exp_hex);
    model_val = from_bcd(exp_hex);
  endtask

  // Runs n full prescaler intervals from a zero prescaler phase, queueing the saturating model result.
  task automatic run_steps(input int n, input logic up);
    addsub = up;
    for (int i = 0; i < n; i++) begin
      if (up) model_val = (model_val >= 9999) ? 9999 : model_val + 1;
      else    model_val = (model_val <= 0) ? 0 : model_val - 1;
      exp_q.push_back(to_bcd(model_val));
    end
    enable = 1'b1;
    repeat (4 * n) @(negedge clk);
    enable = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; addsub = 1'b1; load_preset = 1'b0;
    mode = 2'b00; preset_bcd = 8'h00;

    // 1: reset, mode 00 load, 10 up steps
    repeat (2) @(negedge clk);
    check("reset_count", count, 16'h0000);
    check("reset_tick", {15'd0, tick}, 16'd0);
    reset = 1'b1;
    do_load(2'b00, 8'h00, 16'h0000, "load_mode00");
    check("load_tick", {15'd0, tick}, 16'd0);
    run_steps(10, 1'b1);
    check("s1_count", count, 16'h0010);
    check("s1_at_limit", {15'd0, at_limit}, 16'd0);

    // 2: carry/borrow chain
    do_load(2'b01, 8'h09, 16'h0900, "load_mode01");
    run_steps(1, 1'b0);
    check("s2_borrow", count, 16'h0899);
    run_steps(101, 1'b1);
    check("s2_carry", count, 16'h1000);

    // 3: up saturation with ticks continuing
    do_load(2'b11, 8'h99, 16'h9900, "load_mode11");
    run_steps(102, 1'b1);
    check("s3_sat", count, 16'h9999);
    check("s3_at_limit_up", {15'd0, at_limit}, 16'd1);

    // 4: mode 10, direction-dependent at_limit, down borrow, down saturation
    do_load(2'b10, 8'h00, 16'h9999, "load_mode10");
    addsub = 1'b0;
    #1 check("s4_at_limit_dn9999", {15'd0, at_limit}, 16'd0);
    do_load(2'b01, 8'h01, 16'h0100, "load_0100");
    run_steps(2, 1'b0);
    check("s4_borrow2", count, 16'h0098);
    do_load(2'b01, 8'h00, 16'h0000, "load_0000");
    check("s4_at_limit_dn0", {15'd0, at_limit}, 16'd1);
    run_steps(3, 1'b0);
    check("s4_hold0", count, 16'h0000);

    // 5: load with enable high restarts phase; pause keeps partial interval
    mode = 2'b00; addsub = 1'b1; enable = 1'b1; load_preset = 1'b1;
    @(negedge clk);
    load_preset = 1'b0;
    check("s5_load_over_enable", count, 16'h0000);
    model_val = 0;
    exp_q.push_back(16'h0001);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    check("s5_pause_tick", {15'd0, tick}, 16'd0);
    check("s5_pause_count", count, 16'h0000);
    enable = 1'b1;
    @(negedge clk);
    check("s5_resume1_tick", {15'd0, tick}, 16'd0);
    @(negedge clk);
    check("s5_resume2_tick", {15'd0, tick}, 16'd1);
    check("s5_resume2_count", count, 16'h0001);
    enable = 1'b0;

    // 6: clamp and reset priority over load/enable mid-interval
    do_load(2'b01, 8'h3B, 16'h3900, "clamp_low");
    do_load(2'b01, 8'hA3, 16'h9300, "clamp_high");
    addsub = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; load_preset = 1'b1; preset_bcd = 8'h55;
    @(negedge clk);
    check("s6_reset_count", count, 16'h0000);
    check("s6_reset_tick", {15'd0, tick}, 16'd0);
    reset = 1'b1; load_preset = 1'b0;
    model_val = 0;
    exp_q.push_back(16'h0001);
    repeat (3) @(negedge clk);
    check("s6_full_interval_tick", {15'd0, tick}, 16'd0);
    check("s6_full_interval_count", count, 16'h0000);
    @(negedge clk);
    check("s6_first_step_tick", {15'd0, tick}, 16'd1);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Four-digit BCD up/down time counter, the datapath stage directly downstream of the stopwatch control FSM. It consumes that FSM's `enable`, `addsub` and `load_preset` strobes and the board mode and preset switches. It divides the system clock down to a 0.01 s tick and counts 00.00 to 99.99. Its BCD output feeds the seven-segment display driver.

## Interface

**Parameters**
- `TICK_DIV`, default 1_000_000: `clk` cycles per count step (100 MHz gives 100 Hz). Minimum legal value is 2.
- `PRESCALE_W`, default 20: prescaler width. Must satisfy 2^`PRESCALE_W` >= `TICK_DIV`.

**Ports** (clock and reset first)
- `clk` in 1: system clock. Everything is on the rising edge.
- `reset` in 1: synchronous, active-low. Low on a rising edge clears all state.
- `enable` in 1: count-run qualifier from the FSM.
- `addsub` in 1: direction. 1 = count up, 0 = count down.
- `load_preset` in 1: load the start value selected by `mode`.
- `mode` in 2: 00 = up from zero, 01 = up from preset, 10 = down from 99.99, 11 = down from preset.
- `preset_bcd` in 8: two BCD digits from the switches. They become the seconds field, so the loaded value is `{preset_bcd, 8'h00}`.
- `count` out 16: BCD digits {tens-of-seconds, seconds, tenths, hundredths}.
- `tick` out 1: one-cycle pulse, high in the cycle the new `count` value first appears.
- `at_limit` out 1: 1 when `count` sits at the terminal value for the current `addsub`.

## Operation

**Priority each edge:** `reset` low, then `load_preset`, then `enable`, then hold.

**Reset (low)**
- `count` = 16'h0000, prescaler = 0, `tick` = 0.

**Load (`load_preset` = 1)**
- `count` takes the start value for `mode`:
  - 00 → 16'h0000
  - 01 → `{preset_bcd, 8'h00}`
  - 10 → 16'h9999
  - 11 → `{preset_bcd, 8'h00}`
- A `preset_bcd` nibble greater than 9 is clamped to 9 before loading.
- Prescaler is cleared. `tick` = 0.
- `enable` is ignored during load.

**Run (`enable` = 1, no load)**
- Prescaler increments each cycle.
- When prescaler = `TICK_DIV`-1, it wraps to 0 and a step occurs.

**Up step (`addsub` = 1)**
- BCD increment with ripple carry: a digit at 9 becomes 0 and carries into the next digit.
- At 16'h9999, `count` holds; there is no wrap.

**Down step (`addsub` = 0)**
- BCD decrement with ripple borrow: a digit at 0 becomes 9 and borrows from the next digit.
- At 16'h0000, `count` holds; there is no wrap.

**`tick` on a step**
- `tick` is registered 1 for exactly one cycle on every prescaler wrap, including wraps where `count` holds at its limit.

**Pause (`enable` = 0, no load)**
- Prescaler and `count` hold, so a partially elapsed tick is retained across pause/resume.
- `tick` = 0.

**`at_limit`**
- Combinational decode: (`addsub` & `count` == 16'h9999) | (~`addsub` & `count` == 16'h0000).
- It is not registered.

**Invariants**
- No illegal BCD nibble (>9) ever appears on `count`.
- `count` changes only on reset, load, or a step.

## Timing

- All outputs are registered except `at_limit`.
- **Load latency:** `load_preset` sampled high at edge N gives the new `count` after edge N.
- **Step cadence:** with `enable` continuously high from edge E, the first step lands at edge E+`TICK_DIV`-1 (prescaler 0 → `TICK_DIV`-1 → wrap), then one step every `TICK_DIV` edges. `tick` is high in the cycle after each step edge, coincident with the new `count`.
- **Direction change:** `addsub` changing mid-interval takes effect at the next step and does not disturb the prescaler.
- **Simultaneous events:** `reset` low with `load_preset` or `enable` high gives reset values. `load_preset` with `enable` high gives the load, and the prescaler restarts from 0.
- **Reset mid-count:** `count` goes to 0000 after that edge. The next run starts a full `TICK_DIV` interval.

## Test plan

All scenarios use `TICK_DIV` = 4.

1. **Reset and load, mode 00.** Hold `reset` low 2 cycles, then release with `mode`=00 and `load_preset` pulse → `count`=0000 and `tick`=0 throughout. Then `enable`=1, `addsub`=1 for 40 cycles → `count`=0010, with `tick` pulses every 4 cycles.
2. **BCD carry chain, mode 01.** `mode`=01, `preset_bcd`=8'h09, load → `count`=0900. Force down-count from 0900 → next step gives 0899. From 0999 up → next step gives 1000.
3. **Up saturation.** Load `mode`=11 with `preset_bcd`=8'h99 → `count`=9900. Count up 100 steps → 9999 with `at_limit`=1. Further ticks keep `count`=9999 while `tick` still pulses.
4. **Down to zero, mode 10.** Load → 9999. Set `addsub`=0 and preset 0000 via `mode`=01 with `preset_bcd`=0, then count down → `count`=0000, `at_limit`=1, holds; no 9999 wrap.
5. **Pause preserves phase.** `enable`=1 for 2 cycles, 0 for 10 cycles, then 1 again → next step occurs 2 cycles after resume, not 4.
6. **Priority and clamp.** `preset_bcd`=8'hA3 with `mode`=01 load → `count`=9300. Assert `reset` low together with `load_preset` and `enable` → `count`=0000, `tick`=0.
